// File: rtl/uart_tx_8bit.sv
// uart_tx_8bit: valid/ready byte in, UART frame out (clk, rst, data_in/data_valid/data_ready, tx, busy, done)
module uart_tx_8bit #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic stop_cnt;
  logic [7:0] sh, sh_d;
  logic tx_d, done_d, accept, bit_end, last_stop;
  assign data_ready = state == IDLE && !rst;
  assign accept = data_ready && data_valid;
  assign bit_end = cnt == CW'(CLKS_PER_BIT - 1);
  assign last_stop = stop_cnt == 1'(STOP_BITS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      stop_cnt <= 1'b0;
      sh <= '0;
      tx <= 1'b1;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
      idx <= (state == DATA && bit_end) ? idx + 3'd1 : idx;
      stop_cnt <= (state == STOP && bit_end) ? (last_stop ? 1'b0 : ~stop_cnt) : stop_cnt;
      sh <= sh_d;
      tx <= tx_d;
      done <= done_d;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = bit_end ? DATA : START;
      DATA:    nxt = (bit_end && idx == 3'd7) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
      PARITY:  nxt = bit_end ? STOP : PARITY;
      STOP:    nxt = (bit_end && last_stop) ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
  end
  // sh rotates rather than shifts, so after bit7 it holds the original byte again for parity
  always_comb begin
    sh_d = accept ? data_in : (state == DATA && bit_end) ? {sh[0], sh[7:1]} : sh;
    tx_d = nxt == DATA ? sh_d[0] : nxt == PARITY ? ((^sh_d) ^ (PARITY_ODD != 0)) : nxt != START;
    done_d = state == STOP && nxt == IDLE;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_8bit.sv
// tb_uart_tx_8bit: five configurations driven from one byte list and checked against a frame-timeline model
module tb_uart_tx_8bit;
  localparam int N = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] dv, txw, bsy, dn, rdy, wa;
  logic [7:0] din [N];
  logic [7:0] lst [$];
  int ip [N];
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  task automatic check(string tag, logic got, logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < N; g++) begin : u
    localparam int CPB = g == 4 ? 3 : 4;
    localparam int SB = g >= 3 ? 2 : 1;
    localparam bit PE = g == 1 || g == 2 || g == 4;
    localparam bit PO = g == 2 || g == 4;
    localparam int FL = (1 + 8 + int'(PE) + SB) * CPB;
    int t = -1;
    logic [11:0] fr = '1;
    logic idl;
    uart_tx_8bit #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB), .PARITY_EN(int'(PE)), .PARITY_ODD(int'(PO))) dut (
      .clk(clk), .rst(rst), .data_in(din[g]), .data_valid(dv[g]),
      .data_ready(rdy[g]), .tx(txw[g]), .busy(bsy[g]), .done(dn[g]));
    always @(posedge clk) begin
      if (rst) t <= -1;
      else if ((t < 0 || t == FL) && dv[g]) begin
        t <= 0;
        fr <= {2'b11, PE ? ((^din[g]) ^ PO) : 1'b1, din[g], 1'b0};
      end else if (t < 0 || t == FL) t <= -1;
      else t <= t + 1;
    end
    always @(negedge clk) begin
      idl = t < 0 || t == FL;
      check($sformatf("tx%0d", g), txw[g], idl ? 1'b1 : fr[4'(t / CPB)]);
      check($sformatf("busy%0d", g), bsy[g], !idl);
      check($sformatf("done%0d", g), dn[g], t == FL);
      check($sformatf("ready%0d", g), rdy[g], idl && !rst);
    end
  end
  function automatic logic all_sent();
    for (int g = 0; g < N; g++) if (ip[g] < lst.size()) return 1'b0;
    return 1'b1;
  endfunction
  task automatic step();
    @(negedge clk);
    wa = dv & rdy;
    @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) begin
      if (wa[g]) ip[g]++;
      dv[g] = ip[g] < lst.size();
      din[g] = dv[g] ? lst[ip[g]] : 8'($urandom);
    end
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic send(logic [7:0] b);
    int c = 0;
    lst.push_back(b);
    while (!all_sent() && c < 400) begin
      step();
      c++;
    end
    check("send_timeout", all_sent(), 1'b1);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    for (int g = 0; g < N; g++) begin
      ip[g] = 0;
      din[g] = 8'h5a;
    end
    dv = '1;
    wa = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    dv = '0;
    idle(3);
    send(8'ha5);
    idle(50);
    lst.push_back(8'h00);
    send(8'hff);
    idle(60);
    send(8'h07);
    idle(50);
    send(8'h3c);
    idle(50);
    send(8'h55);
    idle(17);
    pulse_rst();
    idle(3);
    send(8'h81);
    idle(60);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) lst.push_back(8'($urandom));
      send(8'($urandom));
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(0, 40));
        pulse_rst();
      end
      idle($urandom_range(0, 60));
    end
    idle(60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
